// File: rtl/sdram_param.sv
// Shared SDRAM controller definitions: init/work state codes and default timing constants.
// Both the core FSMs and sdram_timer import this package so state codes have one definition.
package sdram_param;

  typedef logic [4:0] state_code_t;

  // Default timings for a 133 MHz clock
  localparam int unsigned DEF_T200US_CYC       = 26600;
  localparam int unsigned DEF_TRP_CYC          = 3;
  localparam int unsigned DEF_TRFC_CYC         = 9;
  localparam int unsigned DEF_TMRD_CYC         = 2;
  localparam int unsigned DEF_TRCD_CYC         = 3;
  localparam int unsigned DEF_CL_CYC           = 3;
  localparam int unsigned DEF_BURST_LEN        = 8;
  localparam int unsigned DEF_TWAIT_CYC        = 3;
  localparam int unsigned DEF_TDAL_CYC         = 5;
  localparam int unsigned DEF_REF_INTERVAL_CYC = 1040;
  localparam int unsigned DEF_REF_GUARD_CYC    = 64;

  localparam int unsigned CNT_W = 8;

  // Init FSM codes
  localparam state_code_t I_NOP      = 5'd0;
  localparam state_code_t I_PRE_CMD  = 5'd1;
  localparam state_code_t I_PRE_TRP  = 5'd2;
  localparam state_code_t I_AR0      = 5'd3;
  localparam state_code_t I_AR0_TRFC = 5'd4;
  localparam state_code_t I_AR1      = 5'd5;
  localparam state_code_t I_AR1_TRFC = 5'd6;
  localparam state_code_t I_MRS      = 5'd7;
  localparam state_code_t I_MRS_TMRD = 5'd8;
  localparam state_code_t I_DONE     = 5'd9;

  // Work FSM codes; disjoint from init codes so the hand-over always restarts the hold count
  localparam state_code_t S_IDLE    = 5'd16;
  localparam state_code_t S_AR      = 5'd17;
  localparam state_code_t S_TRFC    = 5'd18;
  localparam state_code_t S_TRFC1   = 5'd19;
  localparam state_code_t S_ACT     = 5'd20;
  localparam state_code_t S_TRCD    = 5'd21;
  localparam state_code_t S_RD_CMD  = 5'd22;
  localparam state_code_t S_CL      = 5'd23;
  localparam state_code_t S_RD_DATA = 5'd24;
  localparam state_code_t S_RWAIT   = 5'd25;
  localparam state_code_t S_WR_CMD  = 5'd26;
  localparam state_code_t S_WR_DATA = 5'd27;
  localparam state_code_t S_TDAL    = 5'd28;

  function automatic logic is_trfc_state(input state_code_t code);
    return (code == I_AR0_TRFC) || (code == I_AR1_TRFC) ||
           (code == S_TRFC) || (code == S_TRFC1);
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer, owed-refresh tracking, refresh request and ref_domain warning.
// SDRAM_REF_DEBT_EN selects a saturating 3-bit owed counter instead of a single sticky flag.
module sdram_ref_timer
  import sdram_param::*;
#(
  parameter int unsigned REF_INTERVAL_CYC = DEF_REF_INTERVAL_CYC,
  parameter int unsigned REF_GUARD_CYC    = DEF_REF_GUARD_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic sdram_init_done,
  input  logic sdram_ref_ack,
  output logic sdram_ref_req,
  output logic ref_domain
);

  localparam int unsigned TMR_W = $clog2(REF_INTERVAL_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(REF_INTERVAL_CYC - 1);
  localparam logic [TMR_W-1:0] GUARD_START = TMR_W'(REF_INTERVAL_CYC - REF_GUARD_CYC);

  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_n;
  logic             wrap;
  logic             req_n;

  // Interval timer: parked at 0 until init completes, then free-running with wrap
  always_comb begin
    wrap  = sdram_init_done && (tmr_q == TMR_LAST);
    tmr_n = '0;
    if (sdram_init_done && !wrap) begin
      tmr_n = tmr_q + TMR_W'(1);
    end
  end

`ifdef SDRAM_REF_DEBT_EN
  logic [2:0] owed_q;
  logic [2:0] owed_n;

  // Owed-refresh counter; a coincident wrap and ack cancel each other
  always_comb begin
    owed_n = owed_q;
    if (wrap && !sdram_ref_ack) begin
      if (owed_q != 3'd7) begin
        owed_n = owed_q + 3'd1;
      end
    end else if (sdram_ref_ack && !wrap && (owed_q != 3'd0)) begin
      owed_n = owed_q - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owed_q <= '0;
    end else begin
      owed_q <= owed_n;
    end
  end

  assign req_n = (owed_n != 3'd0);
`else
  // Single sticky flag held in the request register itself; a wrap beats an ack
  assign req_n = wrap || (sdram_ref_req && !sdram_ref_ack);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q         <= '0;
      sdram_ref_req <= 1'b0;
      ref_domain    <= 1'b0;
    end else begin
      tmr_q         <= tmr_n;
      sdram_ref_req <= req_n;
      ref_domain    <= req_n || (tmr_n >= GUARD_START);
    end
  end

endmodule

// File: rtl/sdram_timer.sv
// SDRAM timing stage: power-up wait, state-hold counter, end_* wait-release strobes and refresh timing.
// Optional macro SDRAM_REF_DEBT_EN (in sdram_ref_timer) queues up to 7 owed refreshes.
module sdram_timer
  import sdram_param::*;
#(
  parameter int unsigned T200US_CYC       = DEF_T200US_CYC,
  parameter int unsigned TRP_CYC          = DEF_TRP_CYC,
  parameter int unsigned TRFC_CYC         = DEF_TRFC_CYC,
  parameter int unsigned TMRD_CYC         = DEF_TMRD_CYC,
  parameter int unsigned TRCD_CYC         = DEF_TRCD_CYC,
  parameter int unsigned CL_CYC           = DEF_CL_CYC,
  parameter int unsigned BURST_LEN        = DEF_BURST_LEN,
  parameter int unsigned TWAIT_CYC        = DEF_TWAIT_CYC,
  parameter int unsigned TDAL_CYC         = DEF_TDAL_CYC,
  parameter int unsigned REF_INTERVAL_CYC = DEF_REF_INTERVAL_CYC,
  parameter int unsigned REF_GUARD_CYC    = DEF_REF_GUARD_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  init_state,
  input  logic [4:0]  work_state,
  input  logic        sdram_init_done,
  input  logic        sdram_ref_ack,
  output logic        done_200us,
  output logic        end_trp,
  output logic        end_trfc,
  output logic        end_tmrd,
  output logic        end_trcd,
  output logic        end_tcl,
  output logic        end_tread,
  output logic        end_twait,
  output logic        end_twrite,
  output logic        end_tdal,
  output logic        sdram_ref_req,
  output logic        ref_domain
);

  if (T200US_CYC < 2 || TRP_CYC < 2 || TRFC_CYC < 2 || TMRD_CYC < 2 ||
      TRCD_CYC < 2 || CL_CYC < 2 || BURST_LEN < 2 || TWAIT_CYC < 2 ||
      TDAL_CYC < 2 || REF_INTERVAL_CYC < 2 || REF_GUARD_CYC < 2) begin : g_bad_timing
    $error("sdram_timer: all timing parameters and BURST_LEN must be >= 2");
  end

  if (REF_GUARD_CYC >= REF_INTERVAL_CYC) begin : g_bad_guard
    $error("sdram_timer: REF_GUARD_CYC must be smaller than REF_INTERVAL_CYC");
  end

  localparam int unsigned PU_W = $clog2(T200US_CYC);
  localparam logic [PU_W-1:0] PU_LAST = PU_W'(T200US_CYC - 1);
  localparam logic [PU_W-1:0] PU_PRE  = PU_W'(T200US_CYC - 2);

  logic [PU_W-1:0] pu_cnt;

  // Power-up wait: counter parks at its terminal value, flag is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pu_cnt     <= '0;
      done_200us <= 1'b0;
    end else if (pu_cnt != PU_LAST) begin
      pu_cnt <= pu_cnt + PU_W'(1);
      if (pu_cnt == PU_PRE) begin
        done_200us <= 1'b1;
      end
    end
  end

  state_code_t      trk_code;
  state_code_t      prev_code;
  logic             prev_vld;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt;

  assign trk_code = sdram_init_done ? work_state : init_state;

  // Hold count of the code seen this cycle; a new code reads 0 without waiting for an edge
  always_comb begin
    cnt = '0;
    if (prev_vld && (trk_code == prev_code)) begin
      cnt = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_code <= '0;
      prev_vld  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      prev_code <= trk_code;
      prev_vld  <= 1'b1;
      cnt_q     <= cnt;
    end
  end

  // Release strobes: the wait states end so the next command lands exactly *_CYC after its command
  assign end_trp    = (trk_code == I_PRE_TRP)  && (cnt == CNT_W'(TRP_CYC - 2));
  assign end_trfc   = is_trfc_state(trk_code)  && (cnt == CNT_W'(TRFC_CYC - 2));
  assign end_tmrd   = (trk_code == I_MRS_TMRD) && (cnt == CNT_W'(TMRD_CYC - 2));
  assign end_trcd   = (trk_code == S_TRCD)     && (cnt == CNT_W'(TRCD_CYC - 2));
  assign end_tcl    = (trk_code == S_CL)       && (cnt == CNT_W'(CL_CYC - 2));
  assign end_tread  = (trk_code == S_RD_DATA)  && (cnt == CNT_W'(BURST_LEN - 1));
  assign end_twrite = (trk_code == S_WR_DATA)  && (cnt == CNT_W'(BURST_LEN - 2));
  assign end_twait  = (trk_code == S_RWAIT)    && (cnt == CNT_W'(TWAIT_CYC - 1));
  assign end_tdal   = (trk_code == S_TDAL)     && (cnt == CNT_W'(TDAL_CYC - 1));

  sdram_ref_timer #(
    .REF_INTERVAL_CYC (REF_INTERVAL_CYC),
    .REF_GUARD_CYC    (REF_GUARD_CYC)
  ) u_ref_timer (
    .clk             (clk),
    .rst             (rst),
    .sdram_init_done (sdram_init_done),
    .sdram_ref_ack   (sdram_ref_ack),
    .sdram_ref_req   (sdram_ref_req),
    .ref_domain      (ref_domain)
  );

endmodule

// File: tb/tb_sdram_timer.sv
// Self-checking bench for sdram_timer: cycle model of power-up, hold-count strobes and refresh debt,
// plus directed literal checks. Honours SDRAM_REF_DEBT_EN when defined.
module tb_sdram_timer;
  import sdram_param::*;

  localparam int T200 = 26600;
  localparam int TRP  = 3;
  localparam int TRFC = 9;
  localparam int TMRD = 2;
  localparam int TRCD = 3;
  localparam int CL   = 3;
  localparam int BL   = 8;
  localparam int TWT  = 3;
  localparam int TDAL = 5;
  localparam int RIV  = 1040;
  localparam int RGD  = 64;

  localparam int K_TRP = 8, K_TRFC = 7, K_TMRD = 6, K_TRCD = 5, K_TCL = 4;
  localparam int K_TREAD = 3, K_TWAIT = 2, K_TWRITE = 1, K_TDAL = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] init_state = I_NOP;
  logic [4:0] work_state = S_IDLE;
  logic       sdram_init_done = 1'b0;
  logic       sdram_ref_ack = 1'b0;
  logic       done_200us, sdram_ref_req, ref_domain;
  logic       end_trp, end_trfc, end_tmrd, end_trcd, end_tcl;
  logic       end_tread, end_twait, end_twrite, end_tdal;
  logic [8:0] strb;

  assign strb = {end_trp, end_trfc, end_tmrd, end_trcd, end_tcl,
                 end_tread, end_twait, end_twrite, end_tdal};

  always #5 clk = ~clk;

  sdram_timer #(
    .T200US_CYC(T200), .TRP_CYC(TRP), .TRFC_CYC(TRFC), .TMRD_CYC(TMRD),
    .TRCD_CYC(TRCD), .CL_CYC(CL), .BURST_LEN(BL), .TWAIT_CYC(TWT),
    .TDAL_CYC(TDAL), .REF_INTERVAL_CYC(RIV), .REF_GUARD_CYC(RGD)
  ) dut (
    .clk(clk), .rst(rst), .init_state(init_state), .work_state(work_state),
    .sdram_init_done(sdram_init_done), .sdram_ref_ack(sdram_ref_ack),
    .done_200us(done_200us), .end_trp(end_trp), .end_trfc(end_trfc),
    .end_tmrd(end_tmrd), .end_trcd(end_trcd), .end_tcl(end_tcl),
    .end_tread(end_tread), .end_twait(end_twait), .end_twrite(end_twrite),
    .end_tdal(end_tdal), .sdram_ref_req(sdram_ref_req), .ref_domain(ref_domain)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Model state: edges since reset, last tracked code and how long it had been held,
  // consecutive cycles with init done, and refreshes owed.
  int         m_pu = 0;
  logic [4:0] m_code = '0;
  int         m_age = 0;
  bit         m_have = 1'b0;
  int         m_dcyc = 0;
  int         m_owed = 0;

  function automatic logic [4:0] cur_code();
    return sdram_init_done ? work_state : init_state;
  endfunction

  function automatic int cur_age();
    int a;
    a = (m_have && cur_code() == m_code) ? m_age + 1 : 0;
    return (a > 255) ? 255 : a;
  endfunction

  function automatic logic [8:0] exp_strb();
    logic [4:0] c;
    int a;
    logic [8:0] s;
    c = cur_code();
    a = cur_age();
    s = '0;
    s[K_TRP]    = (c == I_PRE_TRP) && (a == TRP - 2);
    s[K_TRFC]   = (c inside {I_AR0_TRFC, I_AR1_TRFC, S_TRFC, S_TRFC1}) && (a == TRFC - 2);
    s[K_TMRD]   = (c == I_MRS_TMRD) && (a == TMRD - 2);
    s[K_TRCD]   = (c == S_TRCD) && (a == TRCD - 2);
    s[K_TCL]    = (c == S_CL) && (a == CL - 2);
    s[K_TREAD]  = (c == S_RD_DATA) && (a == BL - 1);
    s[K_TWRITE] = (c == S_WR_DATA) && (a == BL - 2);
    s[K_TWAIT]  = (c == S_RWAIT) && (a == TWT - 1);
    s[K_TDAL]   = (c == S_TDAL) && (a == TDAL - 1);
    return s;
  endfunction

  function automatic int next_owed();
    bit wrap;
    int o;
    wrap = sdram_init_done && ((m_dcyc % RIV) == RIV - 1);
    o = m_owed;
`ifdef SDRAM_REF_DEBT_EN
    if (wrap && !sdram_ref_ack) o = (o < 7) ? o + 1 : 7;
    else if (sdram_ref_ack && !wrap && o > 0) o = o - 1;
`else
    if (wrap) o = 1;
    else if (sdram_ref_ack) o = 0;
`endif
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pu <= 0; m_code <= '0; m_age <= 0; m_have <= 1'b0; m_dcyc <= 0; m_owed <= 0;
    end else begin
      m_pu   <= m_pu + 1;
      m_code <= cur_code();
      m_age  <= cur_age();
      m_have <= 1'b1;
      m_owed <= next_owed();
      m_dcyc <= sdram_init_done ? m_dcyc + 1 : 0;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk9(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    logic req_e;
    req_e = (m_owed != 0);
    chk1("model_done_200us", done_200us, m_pu >= T200 - 1);
    chk9("model_strobes", strb, exp_strb());
    chk1("model_ref_req", sdram_ref_req, req_e);
    chk1("model_ref_domain", ref_domain, req_e || ((m_dcyc % RIV) >= RIV - RGD));
  endtask

  task automatic settle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) begin
      settle();
      adv();
    end
  endtask

  // Hold a tracked code for n cycles; if k >= 0 strobe k must fire only at hold index 'at'
  task automatic hold(input string name, input logic [4:0] code, input int n,
                      input int k, input int at);
    for (int i = 0; i < n; i++) begin
      if (sdram_init_done) work_state = code;
      else init_state = code;
      settle();
      if (k >= 0) chk1(name, strb[k], (i == at) ? 1'b1 : 1'b0);
      adv();
    end
  endtask

  task automatic pulse_ack();
    sdram_ref_ack = 1'b1;
    settle();
    adv();
    sdram_ref_ack = 1'b0;
  endtask

  int d0;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_done_200us", done_200us, 1'b0);
    chk9("rst_strobes", strb, 9'd0);
    chk1("rst_ref_req", sdram_ref_req, 1'b0);
    chk1("rst_ref_domain", ref_domain, 1'b0);
    #2 rst = 1'b0;
    cyc = 0;
    adv();

    // Init sequence
    hold("init_pre_cmd", I_PRE_CMD, 1, -1, 0);
    hold("lit_end_trp", I_PRE_TRP, 4, K_TRP, 1);
    hold("init_ar0", I_AR0, 1, -1, 0);
    hold("lit_end_trfc_ar0", I_AR0_TRFC, 9, K_TRFC, 7);
    hold("init_ar1", I_AR1, 1, -1, 0);
    hold("lit_end_trfc_ar1", I_AR1_TRFC, 8, K_TRFC, 7);
    hold("init_mrs", I_MRS, 1, -1, 0);
    hold("lit_end_tmrd", I_MRS_TMRD, 3, K_TMRD, 0);
    hold("init_done_state", I_DONE, 1, -1, 0);

    // Power-up boundary
    go_to(26598);
    settle();
    chk1("lit_done_26598", done_200us, 1'b0);
    adv();
    settle();
    chk1("lit_done_26599", done_200us, 1'b1);
    adv();

    go_to(26605);
    sdram_init_done = 1'b1;
    d0 = cyc;
    hold("work_idle", S_IDLE, 2, -1, 0);
    hold("work_act", S_ACT, 1, -1, 0);
    hold("lit_end_trcd", S_TRCD, 3, K_TRCD, 1);
    hold("work_rd_cmd", S_RD_CMD, 1, -1, 0);
    hold("lit_end_tcl", S_CL, 2, K_TCL, 1);
    hold("lit_end_tread", S_RD_DATA, 10, K_TREAD, 7);
    hold("lit_end_twait", S_RWAIT, 4, K_TWAIT, 2);
    hold("work_idle2", S_IDLE, 2, -1, 0);
    hold("work_act2", S_ACT, 1, -1, 0);
    hold("lit_end_trcd2", S_TRCD, 2, K_TRCD, 1);
    hold("work_wr_cmd", S_WR_CMD, 1, -1, 0);
    hold("lit_end_twrite", S_WR_DATA, 8, K_TWRITE, 6);
    hold("lit_end_tdal", S_TDAL, 6, K_TDAL, 4);
    hold("lit_end_trfc_s", S_TRFC, 8, K_TRFC, 7);
    hold("lit_end_trfc_s1", S_TRFC1, 9, K_TRFC, 7);
    hold("work_idle3", S_IDLE, 1, -1, 0);

    // First refresh interval
    go_to(d0 + 975);
    settle();
    chk1("lit_dom_975", ref_domain, 1'b0);
    adv();
    settle();
    chk1("lit_dom_976", ref_domain, 1'b1);
    chk1("lit_req_976", sdram_ref_req, 1'b0);
    adv();
    go_to(d0 + 1039);
    settle();
    chk1("lit_req_1039", sdram_ref_req, 1'b0);
    adv();
    settle();
    chk1("lit_req_1040", sdram_ref_req, 1'b1);
    adv();

    // Single ack retires the request
    go_to(d0 + 1045);
    sdram_ref_ack = 1'b1;
    settle();
    chk1("lit_req_at_ack", sdram_ref_req, 1'b1);
    adv();
    sdram_ref_ack = 1'b0;
    settle();
    chk1("lit_req_after_ack", sdram_ref_req, 1'b0);
    chk1("lit_dom_after_ack", ref_domain, 1'b0);
    adv();

    // Ack coincident with a wrap keeps the request
    go_to(d0 + 2080);
    settle();
    chk1("lit_req_2080", sdram_ref_req, 1'b1);
    adv();
    go_to(d0 + 3119);
    pulse_ack();
    settle();
    chk1("lit_req_wrap_ack", sdram_ref_req, 1'b1);
    adv();
    go_to(d0 + 3125);
    pulse_ack();
    settle();
    chk1("lit_req_3126", sdram_ref_req, 1'b0);
    adv();

    // Three wraps, then three acks
    go_to(d0 + 6240);
    settle();
    chk1("lit_req_3wraps", sdram_ref_req, 1'b1);
    adv();
    go_to(d0 + 6245);
    pulse_ack();
    settle();
`ifdef SDRAM_REF_DEBT_EN
    chk1("lit_req_ack1", sdram_ref_req, 1'b1);
`else
    chk1("lit_req_ack1", sdram_ref_req, 1'b0);
`endif
    adv();
    pulse_ack();
    settle();
`ifdef SDRAM_REF_DEBT_EN
    chk1("lit_req_ack2", sdram_ref_req, 1'b1);
`else
    chk1("lit_req_ack2", sdram_ref_req, 1'b0);
`endif
    adv();
    pulse_ack();
    settle();
    chk1("lit_req_ack3", sdram_ref_req, 1'b0);
    adv();

    // Mid-operation asynchronous reset
    sdram_init_done = 1'b0;
    init_state = I_NOP;
    #1 rst = 1'b1;
    #1;
    chk1("midrst_done_200us", done_200us, 1'b0);
    chk9("midrst_strobes", strb, 9'd0);
    chk1("midrst_ref_req", sdram_ref_req, 1'b0);
    chk1("midrst_ref_domain", ref_domain, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    cyc = 0;
    adv();
    hold("re_pre_cmd", I_PRE_CMD, 1, -1, 0);
    hold("re_end_trp", I_PRE_TRP, 3, K_TRP, 1);
    go_to(10);
    settle();
    chk1("lit_done_rearm", done_200us, 1'b0);
    adv();
    go_to(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
